// File: rtl/riscv_hazard_ctrl.sv
// Hazard/interlock controller for the riscv32i pipeline: tracks in-flight destinations
// after ID and derives forwarding selects, load-use stalls, redirect flushes and CSR freeze.
module riscv_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int NSTAGE     = 3,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int REDIR_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic                        id_rs1_en,
    input  logic [REG_AW-1:0]           id_rs1_addr,
    input  logic                        id_rs2_en,
    input  logic [REG_AW-1:0]           id_rs2_addr,
    input  logic                        id_rd_en,
    input  logic [REG_AW-1:0]           id_rd_addr,
    input  logic                        id_is_load,
    input  logic                        redirect,
    input  logic                        csr_delay,
    output logic                        stall_id,
    output logic                        bubble_exe,
    output logic                        flush_if_id,
    output logic                        freeze,
    output logic [$clog2(NSTAGE+1)-1:0] fwd_rs1_sel,
    output logic [$clog2(NSTAGE+1)-1:0] fwd_rs2_sel,
    output logic [CNT_W-1:0]            stall_cnt
);
    localparam int SEL_W = $clog2(NSTAGE + 1);

    logic [NSTAGE-1:0] vld_q, vld_d;
    logic [NSTAGE-1:0] rd_en_q, rd_en_d;
    logic [NSTAGE-1:0] load_q, load_d;
    logic [REG_AW-1:0] rd_addr_q [NSTAGE];
    logic [REG_AW-1:0] rd_addr_d [NSTAGE];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic             hit1, hit2, rdy1, rdy2;
    logic [SEL_W-1:0] slot1, slot2;
    logic             load_use;

    function automatic logic slot_ready(input int k, input logic is_load);
        return k >= (is_load ? LOAD_READY : ALU_READY);
    endfunction

    always_comb begin
        hit1  = 1'b0;
        rdy1  = 1'b0;
        slot1 = '0;
        hit2  = 1'b0;
        rdy2  = 1'b0;
        slot2 = '0;
        // Scan oldest to youngest so the youngest match is the one left standing.
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (vld_q[k] && rd_en_q[k]) begin
                if (id_rs1_en && id_rs1_addr != '0 && rd_addr_q[k] == id_rs1_addr) begin
                    hit1  = 1'b1;
                    rdy1  = slot_ready(k, load_q[k]);
                    slot1 = SEL_W'(k + 1);
                end
                if (id_rs2_en && id_rs2_addr != '0 && rd_addr_q[k] == id_rs2_addr) begin
                    hit2  = 1'b1;
                    rdy2  = slot_ready(k, load_q[k]);
                    slot2 = SEL_W'(k + 1);
                end
            end
        end
    end

    always_comb begin
        load_use    = id_valid && ((hit1 && !rdy1) || (hit2 && !rdy2));
        stall_id    = 1'b0;
        bubble_exe  = 1'b0;
        flush_if_id = 1'b0;
        freeze      = 1'b0;
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        stall_cnt   = '0;
        if (!reset) begin
            freeze      = csr_delay;
            stall_id    = csr_delay || (load_use && !redirect);
            bubble_exe  = !csr_delay && load_use && !redirect;
            flush_if_id = !csr_delay && redirect;
            fwd_rs1_sel = (hit1 && rdy1) ? slot1 : '0;
            fwd_rs2_sel = (hit2 && rdy2) ? slot2 : '0;
            stall_cnt   = stall_cnt_q;
        end
    end

    always_comb begin
        vld_d       = vld_q;
        rd_en_d     = rd_en_q;
        load_d      = load_q;
        rd_addr_d   = rd_addr_q;
        stall_cnt_d = stall_cnt_q;
        if (!csr_delay) begin
            // Slots younger than the redirecting one are on the wrong path and die as they advance.
            for (int k = NSTAGE - 1; k > 0; k--) begin
                vld_d[k]     = vld_q[k-1] && !(redirect && (k - 1) < REDIR_SLOT);
                rd_en_d[k]   = rd_en_q[k-1];
                load_d[k]    = load_q[k-1];
                rd_addr_d[k] = rd_addr_q[k-1];
            end
            vld_d[0]     = id_valid && !load_use && !redirect;
            rd_en_d[0]   = id_rd_en;
            load_d[0]    = id_is_load;
            rd_addr_d[0] = id_rd_addr;
            if (load_use && !redirect && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            stall_cnt_q <= stall_cnt_d;
        end
        rd_en_q   <= rd_en_d;
        load_q    <= load_d;
        rd_addr_q <= rd_addr_d;
    end
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Bench for riscv_hazard_ctrl: directed pipeline scenarios followed by random traffic,
// every cycle compared against a slot-list reference model.
module tb_riscv_hazard_ctrl;
    localparam int NS = 3;
    localparam int AR = 1;
    localparam int LR = 2;
    localparam int RS = 1;

    logic       clk = 1'b0;
    logic       reset, id_valid, id_rs1_en, id_rs2_en, id_rd_en, id_is_load, redirect, csr_delay;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;

    logic        stall_id, bubble_exe, flush_if_id, freeze;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic [15:0] stall_cnt;

    logic        c2_stall_id, c2_bubble_exe, c2_flush_if_id, c2_freeze;
    logic [1:0]  c2_fwd_rs1_sel, c2_fwd_rs2_sel;
    logic [1:0]  c2_stall_cnt;

    riscv_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1_en(id_rs1_en), .id_rs1_addr(id_rs1_addr),
        .id_rs2_en(id_rs2_en), .id_rs2_addr(id_rs2_addr),
        .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr), .id_is_load(id_is_load),
        .redirect(redirect), .csr_delay(csr_delay),
        .stall_id(stall_id), .bubble_exe(bubble_exe), .flush_if_id(flush_if_id),
        .freeze(freeze), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_cnt(stall_cnt)
    );

    riscv_hazard_ctrl #(.CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1_en(id_rs1_en), .id_rs1_addr(id_rs1_addr),
        .id_rs2_en(id_rs2_en), .id_rs2_addr(id_rs2_addr),
        .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr), .id_is_load(id_is_load),
        .redirect(redirect), .csr_delay(csr_delay),
        .stall_id(c2_stall_id), .bubble_exe(c2_bubble_exe), .flush_if_id(c2_flush_if_id),
        .freeze(c2_freeze), .fwd_rs1_sel(c2_fwd_rs1_sel), .fwd_rs2_sel(c2_fwd_rs2_sel),
        .stall_cnt(c2_stall_cnt)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr    = 0;

    // Reference model: list of in-flight instructions, index 0 = youngest (EXE).
    bit mv[NS];
    bit men[NS];
    int mrd[NS];
    bit mld[NS];
    int mcnt  = 0;
    int mcnt2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_sel(input bit en, input int a, output int sel, output bit notready);
        sel      = 0;
        notready = 0;
        if (en && a != 0) begin
            for (int k = 0; k < NS; k++) begin
                if (mv[k] && men[k] && mrd[k] == a) begin
                    if (k >= (mld[k] ? LR : AR)) sel = k + 1;
                    else notready = 1;
                    break;
                end
            end
        end
    endfunction

    task automatic cyc(input bit v, input bit r1e, input int r1, input bit r2e, input int r2,
                       input bit rde, input int rd, input bit ld, input bit rdr, input bit csr,
                       input bit rst);
        int s1, s2;
        bit n1, n2, lu;
        reset       = rst;
        id_valid    = v;
        id_rs1_en   = r1e;
        id_rs1_addr = 5'(r1);
        id_rs2_en   = r2e;
        id_rs2_addr = 5'(r2);
        id_rd_en    = rde;
        id_rd_addr  = 5'(rd);
        id_is_load  = ld;
        redirect    = rdr;
        csr_delay   = csr;
        #1;
        model_sel(r1e, r1, s1, n1);
        model_sel(r2e, r2, s2, n2);
        lu = v && (n1 || n2);
        chk("freeze",      32'(freeze),      32'(!rst && csr));
        chk("stall_id",    32'(stall_id),    32'(!rst && (csr || (lu && !rdr))));
        chk("bubble_exe",  32'(bubble_exe),  32'(!rst && !csr && lu && !rdr));
        chk("flush_if_id", 32'(flush_if_id), 32'(!rst && !csr && rdr));
        chk("fwd_rs1_sel", 32'(fwd_rs1_sel), rst ? 32'd0 : 32'(s1));
        chk("fwd_rs2_sel", 32'(fwd_rs2_sel), rst ? 32'd0 : 32'(s2));
        chk("stall_cnt",   32'(stall_cnt),   rst ? 32'd0 : 32'(mcnt));
        chk("stall_cnt_w2", 32'(c2_stall_cnt), rst ? 32'd0 : 32'(mcnt2));
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NS; k++) mv[k] = 0;
            mcnt  = 0;
            mcnt2 = 0;
        end else if (!csr) begin
            for (int k = NS - 1; k > 0; k--) begin
                mv[k]  = mv[k-1] && !(rdr && (k - 1) < RS);
                men[k] = men[k-1];
                mrd[k] = mrd[k-1];
                mld[k] = mld[k-1];
            end
            mv[0]  = v && !lu && !rdr;
            men[0] = rde;
            mrd[0] = rd;
            mld[0] = ld;
            if (lu && !rdr) begin
                if (mcnt < 65535) mcnt++;
                if (mcnt2 < 3) mcnt2++;
            end
        end
        @(negedge clk);
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 5, 1, 5, 1, 5, 1, 1, 1, 1);
        // ALU chain with a gap, then back-to-back
        cyc(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        nop();
        cyc(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        cyc(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0);
        cyc(1, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0);
        // load-use
        cyc(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        nop();
        cyc(1, 1, 5, 1, 5, 1, 7, 0, 0, 0, 0);
        cyc(1, 1, 5, 1, 5, 1, 7, 0, 0, 0, 0);
        // x0 never forwards
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        nop();
        cyc(1, 1, 0, 1, 0, 1, 3, 0, 0, 0, 0);
        // two writers of x5: youngest wins
        cyc(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        nop();
        cyc(1, 1, 5, 1, 5, 1, 4, 0, 0, 0, 0);
        // redirect from slot 1 kills slot 0 and the ID entry
        cyc(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 10, 0, 1, 0, 0);
        cyc(1, 1, 8, 1, 9, 1, 11, 0, 0, 0, 0);
        cyc(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
        // CSR freeze in the middle of a load-use stall
        cyc(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        nop();
        cyc(1, 1, 5, 1, 5, 1, 7, 0, 0, 0, 0);
        repeat (4) cyc(1, 1, 5, 1, 5, 1, 7, 0, 1, 1, 0);
        cyc(1, 1, 5, 1, 5, 1, 7, 0, 0, 0, 0);
        cyc(1, 1, 5, 1, 5, 1, 7, 0, 0, 0, 0);
        // back-to-back load-use pushes the 2-bit counter into saturation
        cyc(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        repeat (3) cyc(1, 1, 5, 0, 0, 1, 7, 0, 0, 0, 0);
        // load-use overridden by redirect
        cyc(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0);
        cyc(1, 1, 6, 0, 0, 1, 7, 0, 1, 0, 0);
        // reset mid-stall
        cyc(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        cyc(1, 1, 5, 0, 0, 1, 7, 0, 0, 0, 0);
        cyc(1, 1, 5, 0, 0, 1, 7, 0, 0, 0, 1);
        cyc(1, 1, 5, 0, 0, 1, 7, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3),
                1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
